touch_sense_front: RTL

- Capacitive touch-pad front end. It charges the pad through `sense_drv` and times its discharge on `sense_in`, then classifies each measurement with hysteresis and debounce.
- It produces the `touch_key` level that the touch/LED control logic consumes: idle high, low while touched. A touch therefore appears as a falling edge and a release as a rising edge.
- It also exposes the raw measurement for debug and calibration.

---
 rtl/touch_sense_front.sv | 208 ++++++++++++++++++++
 1 files changed

// File: rtl/touch_sense_front.sv
// Capacitive touch-pad front end: charges the pad, times its discharge, and classifies
// each sample with hysteresis and debounce. Define TOUCH_AUTO_CAL_EN for baseline auto-calibration.
module touch_sense_front #(
    parameter int CHARGE_CYC = 50,
    parameter int CNT_W      = 12,
    parameter int MEAS_MAX   = 4095,
    parameter int THRESH_ON  = 400,
    parameter int THRESH_OFF = 300,
    parameter int DEB_N      = 4,
    parameter int PERIOD_CYC = 50000
) (
    input  logic             sys_clk,
    input  logic             sys_rst_n,
    input  logic             sense_in,
    output logic             sense_drv,
    output logic             touch_key,
    output logic [CNT_W-1:0] meas_val,
    output logic             meas_vld
);

    localparam int PER_W = $clog2(PERIOD_CYC + 1);
    localparam int CHG_W = $clog2(CHARGE_CYC + 1);
    localparam int DEB_W = $clog2(DEB_N + 1);

    // A worst-case measurement that cannot fit in the period chains straight back into CHARGE.
    localparam bit STRETCH = (CHARGE_CYC + MEAS_MAX + 2 >= PERIOD_CYC);

    localparam logic [PER_W-1:0] PER_LAST   = PER_W'(PERIOD_CYC - 1);
    localparam logic [CHG_W-1:0] CHG_LAST   = CHG_W'(CHARGE_CYC - 1);
    localparam logic [CNT_W-1:0] MAX_C      = CNT_W'(MEAS_MAX);
    localparam logic [CNT_W-1:0] MAX_M1     = CNT_W'(MEAS_MAX - 1);
    localparam logic [CNT_W-1:0] THR_ON_C   = CNT_W'(THRESH_ON);
    localparam logic [CNT_W-1:0] THR_OFF_C  = CNT_W'(THRESH_OFF);
    localparam logic [DEB_W-1:0] DEB_C      = DEB_W'(DEB_N);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHARGE,
        S_MEASURE,
        S_EVAL,
        S_WAIT
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic               r_sync1;
    logic               r_sync2;
    logic [PER_W-1:0]   r_per_cnt;
    logic [CHG_W-1:0]   r_chg_cnt;
    logic [CNT_W-1:0]   r_dis_cnt;
    logic [DEB_W-1:0]   r_on_streak;
    logic [DEB_W-1:0]   r_off_streak;
    logic [DEB_W-1:0]   w_on_inc;
    logic [DEB_W-1:0]   w_off_inc;
    logic               r_touched;
    logic               r_touch_key;
    logic [CNT_W-1:0]   r_meas_val;
    logic               r_meas_vld;
    logic [CNT_W-1:0]   w_thr_on;
    logic [CNT_W-1:0]   w_thr_off;
    logic               w_cal_busy;

    assign touch_key = r_touch_key;
    assign meas_val  = r_meas_val;
    assign meas_vld  = r_meas_vld;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_state <= S_IDLE;
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_sync1 <= sense_in;
            r_sync2 <= r_sync1;
        end
    end

    always_comb begin
        w_state_next = r_state;
        sense_drv    = 1'b0;
        unique case (r_state)
            S_IDLE: w_state_next = S_CHARGE;
            S_CHARGE: begin
                sense_drv = 1'b1;
                if (r_chg_cnt == CHG_LAST) w_state_next = S_MEASURE;
            end
            S_MEASURE: begin
                if (!r_sync2 || (r_dis_cnt >= MAX_M1)) w_state_next = S_EVAL;
            end
            S_EVAL: w_state_next = STRETCH ? S_CHARGE : S_WAIT;
            S_WAIT: begin
                if (r_per_cnt >= PER_LAST) w_state_next = S_CHARGE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // Period counter is zero on the first CHARGE cycle, so CHARGE-to-CHARGE spans PERIOD_CYC cycles.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_per_cnt <= '0;
            r_chg_cnt <= '0;
            r_dis_cnt <= '0;
        end else begin
            if ((w_state_next == S_CHARGE) && (r_state != S_CHARGE)) begin
                r_per_cnt <= '0;
            end else if (r_per_cnt < PER_LAST) begin
                r_per_cnt <= r_per_cnt + PER_W'(1);
            end

            if (r_state == S_CHARGE) begin
                r_chg_cnt <= r_chg_cnt + CHG_W'(1);
            end else begin
                r_chg_cnt <= '0;
            end

            if ((r_state == S_CHARGE) && (w_state_next == S_MEASURE)) begin
                r_dis_cnt <= '0;
            end else if ((r_state == S_MEASURE) && r_sync2 && (r_dis_cnt < MAX_C)) begin
                r_dis_cnt <= r_dis_cnt + CNT_W'(1);
            end
        end
    end

`ifdef TOUCH_AUTO_CAL_EN
    logic [3:0]       r_cal_cnt;
    logic [CNT_W+2:0] r_cal_sum;
    logic [CNT_W-1:0] r_baseline;
    logic [CNT_W+2:0] w_sum_next;
    logic [CNT_W:0]   w_on_raw;
    logic [CNT_W:0]   w_off_raw;

    assign w_cal_busy = (r_cal_cnt != 4'd8);
    assign w_sum_next = r_cal_sum + {3'b000, r_dis_cnt};

    // Baseline is the mean of the first eight samples after reset.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_cal_cnt  <= '0;
            r_cal_sum  <= '0;
            r_baseline <= '0;
        end else if ((r_state == S_EVAL) && w_cal_busy) begin
            r_cal_cnt <= r_cal_cnt + 4'd1;
            r_cal_sum <= w_sum_next;
            if (r_cal_cnt == 4'd7) r_baseline <= w_sum_next[CNT_W+2:3];
        end
    end

    assign w_on_raw  = {1'b0, r_baseline} + {1'b0, THR_ON_C};
    assign w_off_raw = {1'b0, r_baseline} + {1'b0, THR_OFF_C};
    assign w_thr_on  = (w_on_raw  > {1'b0, MAX_C}) ? MAX_C : w_on_raw[CNT_W-1:0];
    assign w_thr_off = (w_off_raw > {1'b0, MAX_C}) ? MAX_C : w_off_raw[CNT_W-1:0];
`else
    assign w_cal_busy = 1'b0;
    assign w_thr_on   = THR_ON_C;
    assign w_thr_off  = THR_OFF_C;
`endif

    assign w_on_inc  = (r_on_streak  < DEB_C) ? r_on_streak  + DEB_W'(1) : r_on_streak;
    assign w_off_inc = (r_off_streak < DEB_C) ? r_off_streak + DEB_W'(1) : r_off_streak;

    // Classification only moves on EVAL, so touch_key is stable between samples.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_meas_val   <= '0;
            r_meas_vld   <= 1'b0;
            r_on_streak  <= '0;
            r_off_streak <= '0;
            r_touched    <= 1'b0;
            r_touch_key  <= 1'b1;
        end else begin
            r_meas_vld <= (r_state == S_EVAL);
            if (r_state == S_EVAL) begin
                r_meas_val <= r_dis_cnt;
                if (w_cal_busy) begin
                    r_on_streak  <= '0;
                    r_off_streak <= '0;
                end else if (!r_touched) begin
                    if (r_dis_cnt >= w_thr_on) begin
                        if (w_on_inc == DEB_C) begin
                            r_touched   <= 1'b1;
                            r_touch_key <= 1'b0;
                            r_on_streak <= '0;
                        end else begin
                            r_on_streak <= w_on_inc;
                        end
                    end else begin
                        r_on_streak <= '0;
                    end
                end else begin
                    if (r_dis_cnt < w_thr_off) begin
                        if (w_off_inc == DEB_C) begin
                            r_touched    <= 1'b0;
                            r_touch_key  <= 1'b1;
                            r_off_streak <= '0;
                        end else begin
                            r_off_streak <= w_off_inc;
                        end
                    end else begin
                        r_off_streak <= '0;
                    end
                end
            end
        end
    end

endmodule
